// File: rtl/ik_swift_pkg.sv
// Shared types, register map and helpers for the ik_swift host bridge.
package ik_swift_pkg;

  localparam int FIX_W = 36;

  typedef logic signed [FIX_W-1:0] fix_t;

  localparam logic [6:0] ADDR_CTRL       = 7'h00;
  localparam logic [6:0] ADDR_STATUS     = 7'h01;
  localparam logic [6:0] ADDR_JOINT_TYPE = 7'h02;
  localparam logic [6:0] ADDR_LATENCY    = 7'h03;
  localparam logic [6:0] ADDR_Z_LO       = 7'h08;
  localparam logic [6:0] ADDR_Z_HI       = 7'h0D;
  localparam logic [6:0] ADDR_TGT_LO     = 7'h10;
  localparam logic [6:0] ADDR_TGT_HI     = 7'h1B;
  localparam logic [6:0] ADDR_DH_LO      = 7'h20;
  localparam logic [6:0] ADDR_DH_HI      = 7'h4F;
  localparam logic [6:0] ADDR_DELTA_LO   = 7'h50;
  localparam logic [6:0] ADDR_DELTA_HI   = 7'h5B;

  // state    | meaning
  // IDLE     | solver parked, waiting for start
  // RESET    | ik_rst held high for RST_CYCLES clocks
  // RUN      | ik_en high, counting down the latency window
  // CAPTURE  | one cycle: latch ik_delta, set done
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CAPTURE
  } bridge_state_t;

  // Merge a 32-bit bus word into one half of a 36-bit operand.
  function automatic fix_t set_half(input fix_t cur, input logic hi, input logic [31:0] wd);
    fix_t r;
    r = cur;
    if (hi) r[35:32] = wd[3:0];
    else    r[31:0]  = wd;
    return r;
  endfunction

  // Hi word reads back bits[35:32] sign-extended to a full bus word.
  function automatic logic [31:0] read_half(input fix_t v, input logic hi);
    return hi ? {{28{v[35]}}, v[35:32]} : v[31:0];
  endfunction

endpackage

// File: rtl/ik_swift_host_bridge_run_seq.sv
// Run sequencer: solver reset pulse, fixed enable window, capture strobe.
module ik_swift_run_seq
  import ik_swift_pkg::*;
#(
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] latency,
  output logic        busy,
  output logic        ik_en,
  output logic        ik_rst,
  output logic        start_acc,
  output logic        capture
);

  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES);

  bridge_state_t r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [15:0]   w_lat_eff;

  // A zero latency would never terminate the countdown; run one cycle instead.
  assign w_lat_eff = (latency == 16'd0) ? 16'd1 : latency;
  assign busy      = (r_state != ST_IDLE);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, countdown and solver control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ik_en       = 1'b0;
    ik_rst      = 1'b0;
    start_acc   = 1'b0;
    capture     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RESET;
          w_cnt_nxt   = RST_LOAD;
          start_acc   = 1'b1;
        end
      end
      ST_RESET: begin
        ik_rst = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt <= 16'd1) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = w_lat_eff;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_RUN: begin
        ik_en = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt <= 16'd1) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_CAPTURE: begin
        // An abort landing here still suppresses the capture and done.
        if (!abort) capture = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ik_swift_host_bridge.sv
// Avalon-MM register file that loads ik_swift operands and reads back results.
module ik_swift_host_bridge
  import ik_swift_pkg::*;
#(
  parameter int RUN_CYCLES = 64,
  parameter int RST_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        chipselect,
  input  logic                        read,
  input  logic                        write,
  input  logic [6:0]                  address,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic                        ik_en,
  output logic                        ik_rst,
  output logic [2:0][FIX_W-1:0]       ik_z,
  output logic [5:0]                  ik_joint_type,
  output logic [5:0][3:0][FIX_W-1:0]  ik_dh_param,
  output logic [5:0][FIX_W-1:0]       ik_target,
  input  logic [5:0][FIX_W-1:0]       ik_delta
);

  fix_t        r_z      [3];
  fix_t        r_target [6];
  fix_t        r_dh     [24];
  fix_t        r_delta  [6];
  logic [5:0]  r_joint_type;
  logic [15:0] r_latency;
  logic        r_irq_en;
  logic        r_done;
  logic        r_wr_err;

  logic        w_wr, w_rd;
  logic        w_is_z, w_is_tgt, w_is_dh, w_is_delta, w_is_jt, w_is_operand;
  logic        w_ctrl_wr, w_start, w_abort, w_status_rd;
  logic        w_busy, w_start_acc, w_capture;
  logic [1:0]  w_z_idx;
  logic [2:0]  w_pair_idx;
  logic [4:0]  w_dh_k;
  logic [31:0] w_rdata;

  assign w_wr = chipselect & write;
  assign w_rd = chipselect & read;

  assign w_is_z     = (address >= ADDR_Z_LO)     && (address <= ADDR_Z_HI);
  assign w_is_tgt   = (address >= ADDR_TGT_LO)   && (address <= ADDR_TGT_HI);
  assign w_is_dh    = (address >= ADDR_DH_LO)    && (address <= ADDR_DH_HI);
  assign w_is_delta = (address >= ADDR_DELTA_LO) && (address <= ADDR_DELTA_HI);
  assign w_is_jt    = (address == ADDR_JOINT_TYPE);
  assign w_is_operand = w_is_z | w_is_tgt | w_is_dh | w_is_jt;

  // Each block base is aligned so the pair index falls straight out of the address.
  assign w_z_idx    = address[2:1];
  assign w_pair_idx = address[3:1];
  assign w_dh_k     = 5'((address - ADDR_DH_LO) >> 1);

  assign w_ctrl_wr   = w_wr && (address == ADDR_CTRL);
  assign w_abort     = w_ctrl_wr && writedata[1];
  assign w_start     = w_ctrl_wr && writedata[0] && !writedata[1];
  assign w_status_rd = w_rd && (address == ADDR_STATUS);

  ik_swift_run_seq #(
    .RST_CYCLES (RST_CYCLES)
  ) u_run_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .abort     (w_abort),
    .latency   (r_latency),
    .busy      (w_busy),
    .ik_en     (ik_en),
    .ik_rst    (ik_rst),
    .start_acc (w_start_acc),
    .capture   (w_capture)
  );

  // Operand shadows, config registers and delta capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)  r_z[i]      <= '0;
      for (int i = 0; i < 6; i++)  r_target[i] <= '0;
      for (int i = 0; i < 24; i++) r_dh[i]     <= '0;
      for (int i = 0; i < 6; i++)  r_delta[i]  <= '0;
      r_joint_type <= '0;
      r_latency    <= 16'(RUN_CYCLES);
      r_irq_en     <= 1'b0;
    end else begin
      if (w_wr && !w_busy) begin
        if (w_is_z)   r_z[w_z_idx]         <= set_half(r_z[w_z_idx], address[0], writedata);
        if (w_is_tgt) r_target[w_pair_idx] <= set_half(r_target[w_pair_idx], address[0], writedata);
        if (w_is_dh)  r_dh[w_dh_k]         <= set_half(r_dh[w_dh_k], address[0], writedata);
        if (w_is_jt)  r_joint_type         <= writedata[5:0];
      end
      if (w_wr && (address == ADDR_LATENCY)) r_latency <= writedata[15:0];
      if (w_ctrl_wr) r_irq_en <= writedata[2];
      if (w_capture) begin
        for (int i = 0; i < 6; i++) r_delta[i] <= ik_delta[i];
      end
    end
  end

  // Sticky status bits; a set in the same cycle as a STATUS read wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      if (w_capture)                       r_done <= 1'b1;
      else if (w_start_acc || w_status_rd) r_done <= 1'b0;
      if (w_wr && w_busy && w_is_operand)  r_wr_err <= 1'b1;
      else if (w_status_rd)                r_wr_err <= 1'b0;
    end
  end

  // Read mux.
  always_comb begin
    w_rdata = '0;
    if (address == ADDR_CTRL)         w_rdata = {29'd0, r_irq_en, 2'b00};
    else if (address == ADDR_STATUS)  w_rdata = {29'd0, r_wr_err, r_done, w_busy};
    else if (w_is_jt)                 w_rdata = {26'd0, r_joint_type};
    else if (address == ADDR_LATENCY) w_rdata = {16'd0, r_latency};
    else if (w_is_z)                  w_rdata = read_half(r_z[w_z_idx], address[0]);
    else if (w_is_tgt)                w_rdata = read_half(r_target[w_pair_idx], address[0]);
    else if (w_is_dh)                 w_rdata = read_half(r_dh[w_dh_k], address[0]);
    else if (w_is_delta)              w_rdata = read_half(r_delta[w_pair_idx], address[0]);
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (rst)       readdata <= '0;
    else if (w_rd) readdata <= w_rdata;
  end

  // Continuous operand drive from the shadows.
  always_comb begin
    for (int i = 0; i < 3; i++) ik_z[i] = r_z[i];
    for (int i = 0; i < 6; i++) ik_target[i] = r_target[i];
    for (int j = 0; j < 6; j++) begin
      for (int p = 0; p < 4; p++) ik_dh_param[j][p] = r_dh[4*j + p];
    end
  end

  assign ik_joint_type = r_joint_type;
  assign irq           = r_done & r_irq_en;

endmodule

// File: tb/tb_ik_swift_host_bridge.sv
// Self-checking bench for ik_swift_host_bridge with a read scoreboard.
module tb_ik_swift_host_bridge;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  chipselect = 1'b0;
  logic                  read = 1'b0;
  logic                  write = 1'b0;
  logic [6:0]            address = '0;
  logic [31:0]           writedata = '0;
  logic [31:0]           readdata;
  logic                  irq, ik_en, ik_rst;
  logic [2:0][35:0]      ik_z;
  logic [5:0]            ik_joint_type;
  logic [5:0][3:0][35:0] ik_dh_param;
  logic [5:0][35:0]      ik_target;
  logic [5:0][35:0]      ik_delta;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  ik_swift_host_bridge #(.RUN_CYCLES(64), .RST_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq),
    .ik_en         (ik_en),
    .ik_rst        (ik_rst),
    .ik_z          (ik_z),
    .ik_joint_type (ik_joint_type),
    .ik_dh_param   (ik_dh_param),
    .ik_target     (ik_target),
    .ik_delta      (ik_delta)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [6:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {32'd0, readdata}, {32'd0, e.exp});
    end
  endtask

  task automatic wait_en_high(input string tag);
    int n;
    n = 0;
    while (!ik_en && n < 40) begin tick(); n++; end
    if (!ik_en) chk({tag, "_en_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_en_low(input string tag);
    int n;
    n = 0;
    while (ik_en && n < 80) begin tick(); n++; end
    if (ik_en) chk({tag, "_en_stuck"}, 64'd1, 64'd0);
  endtask

  initial begin
    int n_rst, n_en, first_irq;

    ik_delta    = '0;
    ik_delta[0] = 36'hF_FFFFFFFE;
    ik_delta[1] = 36'h8_00000011;

    // 1: reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_readdata", {32'd0, readdata}, 64'd0);
    chk("rst_ik_en", {63'd0, ik_en}, 64'd0);
    chk("rst_ik_rst", {63'd0, ik_rst}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_z0", {28'd0, ik_z[0]}, 64'd0);
    chk("rst_tgt5", {28'd0, ik_target[5]}, 64'd0);
    chk("rst_dh53", {28'd0, ik_dh_param[5][3]}, 64'd0);
    chk("rst_jt", {58'd0, ik_joint_type}, 64'd0);
    bus_read("rst_latency", 7'h03, 32'd64);
    bus_read("rst_status", 7'h01, 32'd0);

    // 2: operand packing
    bus_write(7'h08, 32'h89ABCDEF);
    bus_write(7'h09, 32'hFFFFFFF5);
    chk("z0_packed", {28'd0, ik_z[0]}, {28'd0, 36'h5_89ABCDEF});
    bus_read("z0_hi", 7'h09, 32'h00000005);
    bus_read("z0_lo", 7'h08, 32'h89ABCDEF);
    bus_write(7'h4E, 32'hCAFEF00D);
    bus_write(7'h4F, 32'h00000003);
    bus_write(7'h22, 32'h11111111);
    chk("dh53", {28'd0, ik_dh_param[5][3]}, {28'd0, 36'h3_CAFEF00D});
    chk("dh01", {28'd0, ik_dh_param[0][1]}, {28'd0, 36'h0_11111111});
    chk("dh10_untouched", {28'd0, ik_dh_param[1][0]}, 64'd0);
    bus_write(7'h02, 32'hFFFFFFE5);
    chk("jt", {58'd0, ik_joint_type}, 64'h25);
    bus_read("unmapped", 7'h60, 32'd0);

    // 3: full run with LATENCY=4
    bus_write(7'h10, 32'h00000000);
    bus_write(7'h11, 32'h0000000F);
    chk("tgt0", {28'd0, ik_target[0]}, {28'd0, 36'hF_00000000});
    bus_read("tgt0_hi", 7'h11, 32'hFFFFFFFF);
    bus_write(7'h03, 32'd4);
    bus_write(7'h00, 32'h5);
    n_rst = 0; n_en = 0; first_irq = 0;
    for (int c = 1; c <= 12; c++) begin
      if (ik_rst) n_rst++;
      if (ik_en) n_en++;
      if (irq && first_irq == 0) first_irq = c;
      tick();
    end
    chk("run_rst_cycles", 64'(n_rst), 64'd2);
    chk("run_en_cycles", 64'(n_en), 64'd4);
    chk("run_done_latency", 64'(first_irq), 64'd8);
    bus_read("run_status", 7'h01, 32'h2);
    chk("irq_cleared", {63'd0, irq}, 64'd0);
    bus_read("delta0_lo", 7'h50, 32'hFFFFFFFE);
    bus_read("delta0_hi", 7'h51, 32'hFFFFFFFF);
    bus_read("delta1_hi", 7'h53, 32'hFFFFFFF8);

    // LATENCY=0 behaves as 1
    bus_write(7'h03, 32'd0);
    bus_write(7'h00, 32'h1);
    n_en = 0;
    for (int c = 1; c <= 8; c++) begin
      if (ik_en) n_en++;
      tick();
    end
    chk("lat0_en_cycles", 64'(n_en), 64'd1);
    bus_read("lat0_status", 7'h01, 32'h2);

    // 4: operand write while busy
    bus_write(7'h03, 32'd8);
    bus_write(7'h00, 32'h1);
    wait_en_high("wrerr");
    bus_write(7'h10, 32'h00001234);
    chk("tgt_locked", {28'd0, ik_target[0]}, {28'd0, 36'hF_00000000});
    bus_read("wrerr_status1", 7'h01, 32'h5);
    bus_read("wrerr_status2", 7'h01, 32'h1);
    wait_en_low("wrerr");
    tick();
    bus_read("wrerr_done", 7'h01, 32'h2);

    // 5: abort on 2nd RUN cycle keeps old delta
    ik_delta[0] = 36'h0_12345678;
    bus_write(7'h00, 32'h1);
    wait_en_high("abort");
    tick();
    bus_write(7'h00, 32'h2);
    chk("abort_en", {63'd0, ik_en}, 64'd0);
    chk("abort_rst", {63'd0, ik_rst}, 64'd0);
    repeat (4) tick();
    bus_read("abort_status", 7'h01, 32'h0);
    bus_read("abort_delta0", 7'h50, 32'hFFFFFFFE);
    bus_write(7'h00, 32'h1);
    wait_en_high("rerun");
    wait_en_low("rerun");
    tick();
    bus_read("rerun_status", 7'h01, 32'h2);
    bus_read("rerun_delta0_lo", 7'h50, 32'h12345678);
    bus_read("rerun_delta0_hi", 7'h51, 32'h0);
    bus_write(7'h00, 32'h3);
    chk("start_abort_rst", {63'd0, ik_rst}, 64'd0);
    bus_read("start_abort_status", 7'h01, 32'h0);

    // 6: rst mid-run
    bus_read("pre_rst_latency", 7'h03, 32'd8);
    bus_write(7'h00, 32'h5);
    wait_en_high("midrst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_en", {63'd0, ik_en}, 64'd0);
    chk("midrst_rst", {63'd0, ik_rst}, 64'd0);
    chk("midrst_readdata", {32'd0, readdata}, 64'd0);
    chk("midrst_irq", {63'd0, irq}, 64'd0);
    chk("midrst_z0", {28'd0, ik_z[0]}, 64'd0);
    chk("midrst_tgt0", {28'd0, ik_target[0]}, 64'd0);
    bus_read("midrst_status", 7'h01, 32'h0);
    bus_read("midrst_latency", 7'h03, 32'd64);
    bus_read("midrst_ctrl", 7'h00, 32'h0);
    bus_read("midrst_delta0", 7'h50, 32'h0);
    bus_read("midrst_dh_lo", 7'h4E, 32'h0);
    bus_read("midrst_jt", 7'h02, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ik_swift_host_bridge.md
Name: ik_swift_host_bridge

Overview:
- Host-side driver for the ik_swift solver interface.
- Accepts 32-bit Avalon-MM slave accesses from the HPS and assembles the 36-bit solver operands: z, joint_type, dh_param and target.
- Sequences the solver through reset and a fixed run window, then captures delta into readable shadow registers.
- Sits between the lightweight HPS-to-FPGA bus and the ik_swift core, on the opposite side of the solver's input/output contract.

Parameters:
- RUN_CYCLES, 64: default solver run length in clocks; reset value of the LATENCY register.
- RST_CYCLES, 2: clocks for which ik_rst is held high before a run.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon slave select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- address  in  7  word address
- writedata  in  32  write data
- readdata  out  32  read data, valid one cycle after read
- irq  out  1  level interrupt; high while STATUS.done=1 and CTRL.irq_en=1
- ik_en  out  1  solver enable
- ik_rst  out  1  solver reset
- ik_z  out  3x36  base joint axis
- ik_joint_type  out  6  joint type vector
- ik_dh_param  out  6x4x36  DH parameters
- ik_target  out  6x36  target coordinates
- ik_delta  in  6x36  solver result

Interface rule (already decided): one clock; reset is synchronous and active-high; ports are named clk and rst.

Behaviour:
Register map (word addresses):
- 0x00 CTRL
  - W bit0: start (self-clearing).
  - W bit1: abort (self-clearing).
  - RW bit2: irq_en.
- 0x01 STATUS, read-only.
  - bit0: busy.
  - bit1: done.
  - bit2: wr_err.
  - Reading STATUS clears done and wr_err.
- 0x02 JOINT_TYPE, bits[5:0].
- 0x03 LATENCY, bits[15:0]. Value 0 is treated as 1.
- 0x08-0x0D: z[i]. lo word at 0x08+2i, hi word at 0x09+2i.
- 0x10-0x1B: target[i], same lo/hi pairing.
- 0x20-0x4F: dh_param[j][p]. Index k=4j+p; lo word at 0x20+2k, hi word at 0x21+2k.
- 0x50-0x5B: delta[i], read-only, same lo/hi pairing.

Word packing:
- lo word carries bits[31:0].
- On write, hi word bits[3:0] carry bits[35:32]; writedata[31:4] is ignored.
- On read, the hi word returns bits[35:32] sign-extended to 32 bits.
- Unmapped reads return 0. Unmapped writes are ignored.

Read timing:
- readdata is registered and valid on the cycle after read&chipselect.
- readdata holds its value otherwise.

Operand drive:
- ik_* operand outputs are driven continuously from the shadow registers.
- Operand writes while busy=1 are dropped and set wr_err.
- This keeps operands stable for the whole run.

FSM states: IDLE, RESET, RUN, CAPTURE.
- IDLE: ik_rst=0, ik_en=0. A start write moves to RESET, clears done and loads cnt.
- RESET: ik_rst=1 for RST_CYCLES clocks, then RUN with cnt=LATENCY.
- RUN: ik_en=1 and cnt decrements each clock. When cnt reaches 1 (the last enabled cycle), go to CAPTURE.
- CAPTURE: latch ik_delta into the delta shadows (ik_en=0), set done, return to IDLE. This state lasts exactly one cycle.
- Cycle count from start write to done visible is 1 + RST_CYCLES + LATENCY + 1.
- busy=1 in every state except IDLE.

Boundary cases:
- Start while busy: ignored.
- Abort while busy: return to IDLE next clock with ik_en=0 and ik_rst=0. Delta shadows are unchanged and done is not set.
- Start and abort in the same write: abort wins.
- STATUS read in the same cycle CAPTURE sets done: done stays set, so it is not lost.
- rst asserted mid-run:
  - FSM returns to IDLE.
  - All shadows, delta, CTRL and STATUS clear to 0.
  - LATENCY returns to RUN_CYCLES.
  - readdata=0, irq=0, ik_en=0, ik_rst=0.

Decomposition:
- Package ik_swift_pkg holds:
  - FIX_W=36;
  - typedef fix_t (logic signed [35:0]);
  - the register address constants;
  - the bridge state enum.
- Natural sub-module: ik_swift_run_seq, which contains the FSM, counter, ik_en/ik_rst generation and the capture strobe.
- The register file and read mux stay in the top level.

Test Plan:
1. Reset, then read LATENCY -> 64. STATUS -> 0. All ik_* outputs -> 0.
2. Write 0x08=0x89ABCDEF, then 0x09=0xFFFFFFF5 -> ik_z[0]=36'h5_89ABCDEF. Read 0x09 -> 0x00000005 (bit35=0, no sign fill).
3. Load target[0]=36'hF_00000000, LATENCY=4, start, with the model driving ik_delta[0]=36'hF_FFFFFFFE.
   - ik_rst is high for 2 cycles, then ik_en is high for exactly 4 cycles.
   - done sets 8 cycles after the start write; irq rises if irq_en=1.
   - Read 0x50 -> 0xFFFFFFFE. Read 0x51 -> 0xFFFFFFFF.
4. During RUN, write 0x10=0x1234 -> ik_target unchanged and wr_err=1. A STATUS read returns wr_err=1 and the next STATUS read returns 0.
5. Start, then abort on the 2nd RUN cycle -> ik_en falls the next clock, done stays 0 and delta shadows keep their prior values. A new start then runs a full sequence.
6. Assert rst during RUN -> next cycle busy=0, LATENCY=64, ik_en=0, all shadows read 0.
